// File: rtl/apb_mem_pkg.sv
// ---------------------------------------------------------------------------
// apb_mem_pkg
//
// Shared definitions for the parametrised APB memory slave:
//   - state_t      : transfer FSM states (IDLE, WAIT, READY)
//   - STRB_W       : byte lanes of the default 32-bit bus
//   - ADDR_LSB     : byte-offset bits of the default 32-bit bus
//   - lanes_of()   : byte lanes for an arbitrary data width
//   - lsb_of()     : byte-offset bits for an arbitrary data width
//   - word_index() : byte address -> word index
//   - access_err() : misalignment / out-of-range check for an address
//
// The localparams describe the default 32-bit build. Parametrised modules
// derive their own values via lanes_of()/lsb_of(), because a package cannot
// see a module parameter.
// ---------------------------------------------------------------------------
package apb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned STRB_W         = DEF_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB       = $clog2(STRB_W);

    function automatic int unsigned lanes_of(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned lsb_of(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Addresses are widened to 64 bits so one function serves every
    // ADDR_WIDTH up to 64 without truncating the upper bits, which matter
    // for the range check.
    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input int unsigned addr_lsb);
        return addr >> addr_lsb;
    endfunction

    // An access is in error when its byte offset is not zero, or when the
    // word it selects lies at or beyond the end of the memory.
    function automatic logic access_err(input logic [63:0] addr,
                                        input int unsigned addr_lsb,
                                        input int unsigned depth);
        logic [63:0] mask;
        logic        misaligned;
        logic        out_of_range;
        mask         = (64'd1 << addr_lsb) - 64'd1;
        misaligned   = ((addr & mask) != 64'd0);
        out_of_range = (word_index(addr, addr_lsb) >= 64'(depth));
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// ---------------------------------------------------------------------------
// apb_mem_array
//
// DEPTH x DATA_WIDTH word storage for apb_mem_slave.
//
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write enable
//   waddr  in   word index written when we=1
//   wdata  in   write data
//   wstrb  in   per-byte write enables (all ones when strobes are disabled)
//   raddr  in   word index for the combinational read port
//   rdata  out  data at raddr, combinational; the parent registers it
//
// The contents have no reset. The parent only asserts we for in-range
// indices, so the write path needs no bounds check of its own.
// ---------------------------------------------------------------------------
module apb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]     rdata
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write: only the lanes with their strobe set are updated,
    // so a partial write leaves the other bytes of the word intact.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int lane = 0; lane < LANES; lane++) begin
                if (wstrb[lane]) begin
                    mem[waddr][lane*8 +: 8] <= wdata[lane*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//
// APB slave with an internal word-addressed memory. It has configurable
// data width, depth and number of wait states. All outputs are registered.
// An error response is returned for misaligned and out-of-range accesses.
// When PSEL drops during the wait phase, the transfer is abandoned without
// writing.
//
// Optional feature macro: APB_MEM_PSTRB_EN
//   defined     -> PSTRB port exists; writes update only strobed byte lanes
//   not defined -> no PSTRB port; every valid write updates the full word
//
// Parameters:
//   ADDR_WIDTH   PADDR width (up to 64)
//   DATA_WIDTH   PWDATA/PRDATA width, 32 or 64
//   DEPTH        number of memory words, >= 2
//   WAIT_STATES  PREADY-low cycles in the access phase, 0..15
//
// Ports:
//   PCLK     in   bus clock, rising edge
//   PRESET   in   synchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access phase indicator
//   PADDR    in   byte address
//   PWRITE   in   1 = write, 0 = read
//   PWDATA   in   write data
//   PSTRB    in   byte strobes (APB_MEM_PSTRB_EN only)
//   PRDATA   out  read data, registered
//   PREADY   out  transfer complete, registered
//   PSLVERR  out  error response, registered
// ---------------------------------------------------------------------------
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_MEM_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int unsigned BUS_STRB_W   = lanes_of(DATA_WIDTH);
    localparam int unsigned BUS_ADDR_LSB = lsb_of(DATA_WIDTH);
    localparam int unsigned MEM_DEPTH    = DEPTH;
    localparam int          IDX_W        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD    = 4'(WAIT_STATES);

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic                    err_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    pready_q;
    logic                    pslverr_q;

    logic                    setup;
    logic                    setup_err;
    logic [IDX_W-1:0]        setup_idx;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    wr_en;
    logic [BUS_STRB_W-1:0]   byte_en;

    // Address decode for the current setup cycle. The index is truncated
    // to the array width. That is harmless because an out-of-range address
    // raises the error flag, and an errored access neither writes nor
    // returns memory data.
    assign setup     = PSEL && !PENABLE;
    assign setup_err = access_err(64'(PADDR), BUS_ADDR_LSB, MEM_DEPTH);
    assign setup_idx = IDX_W'(word_index(64'(PADDR), BUS_ADDR_LSB));

    // The write commits at the READY edge. It needs the live handshake
    // (the master may still have dropped PSEL) and a clean address. Reset
    // on the same edge wins, so an interrupted transfer never writes.
    assign wr_en = (state == READY) && PSEL && PENABLE && PWRITE &&
                   !err_q && !PRESET;

`ifdef APB_MEM_PSTRB_EN
    assign byte_en = PSTRB;
`else
    assign byte_en = '1;
`endif

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (PCLK),
        .we    (wr_en),
        .waddr (idx_q),
        .wdata (PWDATA),
        .wstrb (byte_en),
        .raddr (setup_idx),
        .rdata (rd_data)
    );

    // Transfer FSM. The output registers are loaded on the edge that
    // enters a state, so PREADY/PSLVERR/PRDATA are valid for the whole of
    // that state and never depend combinationally on bus inputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    if (setup) begin
                        err_q    <= setup_err;
                        idx_q    <= setup_idx;
                        wait_cnt <= WAIT_LOAD;
                        // Read data is captured here, at the setup edge.
                        // It then holds through WAIT and READY.
                        if (!PWRITE && !setup_err) begin
                            prdata_q <= rd_data;
                        end
                        if (WAIT_STATES == 0) begin
                            state     <= READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= setup_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    wait_cnt  <= wait_cnt - 4'd1;
                    if (!PSEL) begin
                        // Master abort: drop everything and go back to IDLE.
                        state    <= IDLE;
                        prdata_q <= '0;
                        wait_cnt <= '0;
                    end else if (wait_cnt == 4'd1) begin
                        state     <= READY;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                    end
                end

                READY: begin
                    // Completion lasts exactly one cycle. A setup cycle in the
                    // next cycle is picked up by IDLE, so there is no bubble.
                    state     <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end

                default: begin
                    state     <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end
            endcase
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- Parametrised APB slave with internal word-addressed memory; next generation of the team's fixed 32x32 APB memory slave.
- Adds configurable data width, depth and wait states, plus registered outputs.
- Adds error response for misaligned and out-of-range accesses, and clean abort when PSEL drops mid-transfer.
- Sits on the APB bus behind the bridge and serves as the UVM environment's scalable DUT.

Parameters:
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width; legal values 32 or 64.
- DEPTH, 32: number of memory words; any value ≥ 2.
- WAIT_STATES, 0: PREADY-low cycles inserted in the access phase; range 0..15.

Ports:
- PCLK  in  1  bus clock, all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte write strobes; present only with APB_MEM_PSTRB_EN.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer complete, registered.
- PSLVERR  out  1  error response, registered.

Behaviour:
- Reset (PRESET=1 at rising PCLK): state=IDLE, wait counter=0, PREADY=0, PSLVERR=0, PRDATA=0.
- Memory contents are not reset. Reset mid-transfer abandons the transfer; no write occurs.
- Word index = PADDR >> log2(DATA_WIDTH/8).
- Error condition ERR: the address is not aligned to DATA_WIDTH/8 bytes, or word index ≥ DEPTH.
- State IDLE: PREADY=0.
  - A setup cycle (PSEL=1, PENABLE=0) latches ERR and loads the counter with WAIT_STATES.
  - For a read without ERR, the setup cycle also loads PRDATA from memory; for a read with ERR it loads PRDATA=0.
  - Next state is READY if WAIT_STATES==0, otherwise WAIT.
  - All other input combinations stay in IDLE.
- State WAIT: PREADY=0, PSLVERR=0; the counter decrements each cycle.
  - Counter==1 and PSEL=1: next state READY.
  - PSEL=0 (master abort): next state IDLE, no write, outputs remain 0.
- State READY: PREADY=1; PSLVERR equals the latched ERR; PRDATA holds the read value (0 on write or ERR).
  - If PSEL=1, PENABLE=1, PWRITE=1 and ERR=0, the word is written at this rising edge.
  - Next state is always IDLE, and PREADY, PSLVERR and PRDATA clear next cycle.
  - A following setup cycle is handled by IDLE, so back-to-back transfers have no bubble.
- Latency: PREADY rises in access-phase cycle WAIT_STATES+1. A transfer takes 2+WAIT_STATES cycles.
- PADDR, PWRITE and PWDATA are sampled at the setup edge, and PWDATA again at the write edge. The master holds them stable per APB.
- PSLVERR is 0 whenever PREADY=0.
- A read that follows a write to the same word returns the new data.

Optional Feature:
- APB_MEM_PSTRB_EN defined:
  - PSTRB port exists.
  - Writes update only the byte lanes whose strobe is 1.
  - PSTRB=0 on a write is a legal no-op with PSLVERR=0.
  - Reads ignore PSTRB.
- Not defined:
  - No PSTRB port.
  - Every valid write updates the full word.

Decomposition:
- Package apb_mem_pkg:
  - State enum (IDLE, WAIT, READY).
  - Localparams STRB_W=DATA_WIDTH/8 and ADDR_LSB=log2(STRB_W).
  - Function for the word-index/range check.
- Sub-module apb_mem_array:
  - DEPTH x DATA_WIDTH storage.
  - Synchronous write with byte enables (tied all-ones without the macro).
  - Combinational read port, registered by the parent.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x04, then read 0x04 → PREADY high in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0, 2 cycles per transfer.
- WAIT_STATES=3: read 0x08 → PREADY low for exactly 3 access cycles, high on the 4th, PSLVERR=0.
- DEPTH=32: write to 0x80 (index 32), then to 0x06 (misaligned) → PSLVERR=1 with PREADY each time; memory unchanged (reading 0x00..0x7C shows prior data).
- WAIT_STATES=2: deassert PSEL after 1 wait cycle during a write of 0x12345678 to 0x10 → return to IDLE with PREADY never high; a later read of 0x10 returns the old value.
- APB_MEM_PSTRB_EN: write 0xFFFFFFFF to 0x0C, then write 0x00000000 with PSTRB=4'b0101 → read returns 0xFF00FF00.
- Back-to-back writes to 0x00, 0x04, 0x08 with PRESET pulsed during the 2nd transfer's access phase → outputs 0 the cycle after reset, 2nd write not committed, 3rd write completes normally.
